// File: rtl/ahb_dma_ctrl.sv
// AHB-Lite register slave that programs and launches a single-channel DMA master.
// Optional feature macro DMA_IRQ_EN: adds IRQEN at offset 0x14 and a registered DMAirq output.
module ahb_dma_ctrl (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        DMAstart,
  input  logic        DMAdone,
  output logic [31:0] DMAsrc,
  output logic [31:0] DMAdst,
  output logic [31:0] DMAlen,
  output logic [1:0]  DMAsize,
  output logic        DMAirq
);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} resp_state_e;

  localparam logic [2:0] IdxSrc    = 3'd0;
  localparam logic [2:0] IdxDst    = 3'd1;
  localparam logic [2:0] IdxLen    = 3'd2;
  localparam logic [2:0] IdxCtrl   = 3'd3;
  localparam logic [2:0] IdxStatus = 3'd4;
  localparam logic [2:0] IdxIrqen  = 3'd5;

  resp_state_e state_q, state_d;
  logic        hreadyout_q, hreadyout_d;
  logic        hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        dph_wr_q, dph_wr_d;
  logic [2:0]  dph_idx_q, dph_idx_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  size_q, size_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        dmadone_q;
  logic        irqen_val;

  logic        ap_valid;
  logic        ap_err;
  logic        ap_ok;
  logic        done_evt;
  logic [31:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign ap_valid = HSEL & HTRANS[1] & HREADY;
  assign done_evt = DMAdone & ~dmadone_q & busy_q;

  // Register side effects of the completing data phase, then DMA completion (set wins over W1C).
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    size_d  = size_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = 1'b0;
    if (dph_wr_q) begin
      case (dph_idx_q)
        IdxSrc: src_d = HWDATA;
        IdxDst: dst_d = HWDATA;
        IdxLen: len_d = HWDATA;
        IdxCtrl: begin
          size_d = HWDATA[1:0];
          if (HWDATA[8] && !busy_q && (len_q != 32'd0)) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        IdxStatus: begin
          if (HWDATA[1]) done_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (done_evt) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (HADDR[4:2])
      IdxSrc:    rdata = src_q;
      IdxDst:    rdata = dst_q;
      IdxLen:    rdata = len_q;
      IdxCtrl:   rdata = {30'd0, size_q};
      IdxStatus: rdata = {30'd0, done_q, busy_q};
      IdxIrqen:  rdata = {31'd0, irqen_val};
      default:   rdata = 32'd0;
    endcase
  end

  // busy_d is used so a write landing on the same edge as a START or done event sees the new state.
  assign ap_err = ap_valid &
                  ((HSIZE != 3'b010) | (HWRITE & (HADDR[4:2] <= IdxCtrl) & busy_d));
  assign ap_ok  = ap_valid & ~ap_err;

  always_comb begin
    dph_wr_d    = ap_ok & HWRITE;
    dph_idx_d   = HADDR[4:2];
    hrdata_d    = (ap_ok && !HWRITE) ? rdata : 32'd0;
    state_d     = StIdle;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    unique case (state_q)
      StErr1: begin
        state_d     = StErr2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        if (ap_err) begin
          state_d     = StErr1;
          hreadyout_d = 1'b0;
          hresp_d     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
      dph_wr_q    <= 1'b0;
      dph_idx_q   <= 3'd0;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
      len_q       <= 32'd0;
      size_q      <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      dmadone_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      dph_wr_q    <= dph_wr_d;
      dph_idx_q   <= dph_idx_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      size_q      <= size_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_q     <= start_d;
      dmadone_q   <= DMAdone;
    end
  end

`ifdef DMA_IRQ_EN
  logic irqen_q, irqen_d;
  logic irq_q, irq_d;

  always_comb begin
    irqen_d = irqen_q;
    if (dph_wr_q && (dph_idx_q == IdxIrqen)) irqen_d = HWDATA[0];
    irq_d = done_q & irqen_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign irqen_val = irqen_q;
  assign DMAirq    = irq_q;
`else
  assign irqen_val = 1'b0;
  assign DMAirq    = 1'b0;
`endif

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign DMAstart  = start_q;
  assign DMAsrc    = src_q;
  assign DMAdst    = dst_q;
  assign DMAlen    = len_q;
  assign DMAsize   = size_q;

endmodule
